// File: rtl/ikaopll_bus_writer_pkg.sv
// rtl/ikaopll_bus_writer_pkg.sv - shared state encoding and OPLL wait defaults
package ikaopll_bus_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_WAIT,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_WAIT
    } state_t;

    // Minimum phiM ticks the OPLL needs after an address / data write
    localparam int OPLL_ADDR_WAIT = 12;
    localparam int OPLL_DATA_WAIT = 84;

endpackage

// File: rtl/ikaopll_bus_writer_fifo.sv
// rtl/ikaopll_bus_writer_fifo.sv - request FIFO holding {addr, data} pairs
module ikaopll_bus_writer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // full is taken from the current count, so a pop never frees room for a same-edge push
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // storage array; contents are don't-care until written so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ikaopll_bus_writer.sv
// rtl/ikaopll_bus_writer.sv - paced OPLL CPU-port write master with request FIFO
module ikaopll_bus_writer
    import ikaopll_bus_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STROBE_LEN = 2,
    parameter int ADDR_WAIT  = OPLL_ADDR_WAIT,
    parameter int DATA_WAIT  = OPLL_DATA_WAIT
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_phiM_PCEN_n,
    input  logic       i_REQ_VALID,
    output logic       o_REQ_READY,
    input  logic [7:0] i_REQ_ADDR,
    input  logic [7:0] i_REQ_DATA,
    output logic       o_BUSY,
    output logic       o_CS_n,
    output logic       o_WR_n,
    output logic       o_A0,
    output logic [7:0] o_D,
    output logic       o_D_OE
);

    // counter reload values: the counter holds remaining ticks minus one
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_LEN - 1);
    localparam logic [7:0] ADDR_LOAD   = 8'(ADDR_WAIT - 1);
    localparam logic [7:0] DATA_LOAD   = 8'(DATA_WAIT - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        cs_q, cs_nx;
    logic        wr_q, wr_nx;
    logic        a0_q, a0_nx;
    logic [7:0]  d_q, d_nx;
    logic        oe_q, oe_nx;
    logic        busy_q, busy_nx;
    logic [7:0]  hold_q, hold_nx;
    logic        tick;
    logic        pop;
    logic        load_head;
    logic        full;
    logic        empty;
    logic [15:0] head;
    logic        push_fire;

    assign tick        = ~i_phiM_PCEN_n;
    assign o_REQ_READY = ~full;
    assign push_fire   = i_REQ_VALID & ~full;

    ikaopll_bus_writer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (i_EMUCLK),
        .rst       (i_RST),
        .push      (i_REQ_VALID),
        .push_data ({i_REQ_ADDR, i_REQ_DATA}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // next state, counter and registered-output values; bus outputs hold unless changed here
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cs_nx     = cs_q;
        wr_nx     = wr_q;
        a0_nx     = a0_q;
        d_nx      = d_q;
        oe_nx     = oe_q;
        hold_nx   = hold_q;
        pop       = 1'b0;
        load_head = 1'b0;
        busy_nx   = 1'b0;

        case (state)
            ST_IDLE: load_head = ~empty;
            ST_A_SETUP, ST_D_SETUP: begin
                if (tick) begin
                    state_nx = (state == ST_A_SETUP) ? ST_A_STROBE : ST_D_STROBE;
                    cnt_nx   = STROBE_LOAD;
                    wr_nx    = 1'b0;
                end
            end
            ST_A_STROBE, ST_D_STROBE: begin
                if (tick) begin
                    if (cnt == 8'd0) begin
                        state_nx = (state == ST_A_STROBE) ? ST_A_WAIT : ST_D_WAIT;
                        cnt_nx   = (state == ST_A_STROBE) ? ADDR_LOAD : DATA_LOAD;
                        wr_nx    = 1'b1;
                    end else begin
                        cnt_nx = cnt - 8'd1;
                    end
                end
            end
            ST_A_WAIT: begin
                if (tick) begin
                    cs_nx = 1'b1;
                    if (cnt == 8'd0) begin
                        state_nx = ST_D_SETUP;
                        cnt_nx   = 8'd0;
                        cs_nx    = 1'b0;
                        a0_nx    = 1'b1;
                        d_nx     = hold_q;
                    end else begin
                        cnt_nx = cnt - 8'd1;
                    end
                end
            end
            ST_D_WAIT: begin
                if (tick) begin
                    cs_nx = 1'b1;
                    if (cnt == 8'd0) begin
                        if (!empty) begin
                            load_head = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                            oe_nx    = 1'b0;
                        end
                    end else begin
                        cnt_nx = cnt - 8'd1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // start a new pair: address phase setup with the FIFO head
        if (load_head) begin
            pop      = 1'b1;
            hold_nx  = head[7:0];
            state_nx = ST_A_SETUP;
            cnt_nx   = 8'd0;
            cs_nx    = 1'b0;
            wr_nx    = 1'b1;
            a0_nx    = 1'b0;
            d_nx     = head[15:8];
            oe_nx    = 1'b1;
        end

        busy_nx = (state_nx != ST_IDLE) | (~empty & ~pop) | push_fire;
    end

    // state, counter and output registers
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            state  <= ST_IDLE;
            cnt    <= 8'd0;
            cs_q   <= 1'b1;
            wr_q   <= 1'b1;
            a0_q   <= 1'b0;
            d_q    <= 8'd0;
            oe_q   <= 1'b0;
            busy_q <= 1'b0;
            hold_q <= 8'd0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            cs_q   <= cs_nx;
            wr_q   <= wr_nx;
            a0_q   <= a0_nx;
            d_q    <= d_nx;
            oe_q   <= oe_nx;
            busy_q <= busy_nx;
            hold_q <= hold_nx;
        end
    end

    assign o_CS_n = cs_q;
    assign o_WR_n = wr_q;
    assign o_A0   = a0_q;
    assign o_D    = d_q;
    assign o_D_OE = oe_q;
    assign o_BUSY = busy_q;

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// tb/tb_ikaopll_bus_writer.sv - directed self-checking bench for ikaopll_bus_writer
module tb_ikaopll_bus_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pcen_n = 1'b0;
    logic       valid = 1'b0;
    logic       valid2 = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data = 8'h00;

    logic       ready, busy, cs_n, wr_n, a0, oe;
    logic [7:0] d;
    logic       ready2, busy2, cs_n2, wr_n2, a02, oe2;
    logic [7:0] d2;

    ikaopll_bus_writer u_dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phiM_PCEN_n (pcen_n),
        .i_REQ_VALID   (valid),
        .o_REQ_READY   (ready),
        .i_REQ_ADDR    (addr),
        .i_REQ_DATA    (data),
        .o_BUSY        (busy),
        .o_CS_n        (cs_n),
        .o_WR_n        (wr_n),
        .o_A0          (a0),
        .o_D           (d),
        .o_D_OE        (oe)
    );

    ikaopll_bus_writer #(
        .FIFO_DEPTH (4),
        .STROBE_LEN (1),
        .ADDR_WAIT  (1),
        .DATA_WAIT  (255)
    ) u_dut2 (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phiM_PCEN_n (pcen_n),
        .i_REQ_VALID   (valid2),
        .o_REQ_READY   (ready2),
        .i_REQ_ADDR    (addr),
        .i_REQ_DATA    (data),
        .o_BUSY        (busy2),
        .o_CS_n        (cs_n2),
        .o_WR_n        (wr_n2),
        .o_A0          (a02),
        .o_D           (d2),
        .o_D_OE        (oe2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    bit div4 = 1'b0;
    int ph = 0;
    always @(negedge clk) begin
        if (div4) begin
            ph = (ph + 1) % 4;
            pcen_n = (ph != 0);
        end else begin
            pcen_n = 1'b0;
        end
    end

    typedef struct {
        logic [8:0] bus;
        int         t;
    } ev_t;
    ev_t  log_q[$];
    logic prev_wr = 1'b1;

    always @(negedge clk) begin
        if (prev_wr && !wr_n) log_q.push_back('{{a0, d}, cyc});
        prev_wr = wr_n;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return cs_n;
            1:       return wr_n;
            2:       return busy;
            3:       return wr_n2;
            default: return busy2;
        endcase
    endfunction

    task automatic wait_lvl(input int w, input logic lvl, input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (sig(w) == lvl) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("wait_timeout", 32'(w), 32'hFFFF_FFFF);
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] dd);
        addr  = a;
        data  = dd;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    initial begin
        int tcs, t1, t2, tb, n, stalls, guard, k;
        logic r;
        logic [8:0] eb;

        // reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_cs", cs_n, 1);
        chk("rst_wr", wr_n, 1);
        chk("rst_a0_d", {a0, d}, 0);
        chk("rst_oe", oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        rst = 1'b0;
        repeat (2) step();

        // single write, phiM every cycle
        push(8'h10, 8'hAB);
        chk("t1_busy_rise", busy, 1);
        chk("t1_cs_pre", cs_n, 1);
        step();
        tcs = cyc;
        chk("t1_setup", {cs_n, wr_n, a0, oe, d}, {4'b0101, 8'h10});
        wait_lvl(1, 1'b0, 10, t1);
        chk("t1_wr_lat", t1 - tcs, 1);
        chk("t1_abus", {a0, d}, 9'h010);
        n = 0;
        while (wr_n == 1'b0 && n < 20) begin
            n++;
            step();
        end
        chk("t1_wr_width", n, 2);
        wait_lvl(1, 1'b0, 40, t2);
        chk("t1_spacing", t2 - t1, 15);
        chk("t1_dbus", {a0, d}, 9'h1AB);
        wait_lvl(2, 1'b0, 200, tb);
        chk("t1_busy_len", tb - tcs, 102);
        chk("t1_idle", {cs_n, wr_n, oe, a0, d}, {4'b1101, 8'hAB});

        // phiM one tick in four
        div4 = 1'b1;
        repeat (3) step();
        push(8'h10, 8'hAB);
        wait_lvl(1, 1'b0, 40, t1);
        n = 0;
        while (wr_n == 1'b0 && n < 40) begin
            n++;
            step();
        end
        chk("t2_wr_width", n, 8);
        wait_lvl(1, 1'b0, 100, t2);
        chk("t2_spacing", t2 - t1, 60);
        chk("t2_dbus", {a0, d}, 9'h1AB);
        wait_lvl(2, 1'b0, 600, tb);
        chk("t2_busy_len", tb - t1, 404);
        div4 = 1'b0;
        repeat (3) step();

        // back-pressure: six back-to-back requests into a four-entry FIFO
        log_q.delete();
        k = 0;
        stalls = 0;
        guard = 0;
        while (k < 6 && guard < 2000) begin
            addr  = 8'(8'h20 + k);
            data  = 8'(8'hC0 + k);
            valid = 1'b1;
            r = ready;
            step();
            if (r) k++;
            else stalls++;
            guard++;
        end
        valid = 1'b0;
        chk("t3_pushed", k, 6);
        chk("t3_ready_dropped", stalls > 0, 1);
        wait_lvl(2, 1'b0, 900, tb);
        chk("t3_strobes", log_q.size(), 12);
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            eb = (i % 2 == 0) ? {1'b0, 8'(8'h20 + i / 2)} : {1'b1, 8'(8'hC0 + i / 2)};
            chk($sformatf("t3_bus%0d", i), log_q[i].bus, eb);
            if (i > 0) chk($sformatf("t3_gap%0d", i), log_q[i].t - log_q[i-1].t, (i % 2 == 1) ? 15 : 87);
        end
        chk("t3_ready_end", ready, 1);

        // reset during data strobe
        log_q.delete();
        push(8'h55, 8'h66);
        wait_lvl(1, 1'b0, 20, t1);
        wait_lvl(1, 1'b1, 20, t1);
        wait_lvl(1, 1'b0, 40, t2);
        chk("t4_in_dstrobe", {wr_n, a0}, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_rst", {cs_n, wr_n, a0, oe, d, busy, ready}, {4'b1100, 8'h00, 2'b01});
        repeat (2) step();
        rst = 1'b0;
        log_q.delete();
        repeat (200) step();
        chk("t4_no_strobe", log_q.size(), 0);
        chk("t4_idle_busy", busy, 0);
        push(8'h77, 8'h88);
        wait_lvl(2, 1'b0, 200, tb);
        chk("t4_fresh_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("t4_fresh_addr", log_q[0].bus, 9'h077);
            chk("t4_fresh_data", log_q[1].bus, 9'h188);
        end

        // push on the same edge that IDLE pops the previous entry
        repeat (2) step();
        log_q.delete();
        addr  = 8'h31;
        data  = 8'h41;
        valid = 1'b1;
        step();
        addr  = 8'h32;
        data  = 8'h42;
        r = ready;
        step();
        valid = 1'b0;
        chk("t5_ready", r, 1);
        chk("t5_first_pop", {cs_n, d}, {1'b0, 8'h31});
        wait_lvl(2, 1'b0, 400, tb);
        chk("t5_count", log_q.size(), 4);
        if (log_q.size() >= 4) begin
            chk("t5_e0", log_q[0].bus, 9'h031);
            chk("t5_e1", log_q[1].bus, 9'h141);
            chk("t5_e2", log_q[2].bus, 9'h032);
            chk("t5_e3", log_q[3].bus, 9'h142);
        end

        // parameter corners on the second instance
        addr   = 8'h5A;
        data   = 8'hA5;
        valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        step();
        tcs = cyc;
        chk("t6_cs", cs_n2, 0);
        wait_lvl(3, 1'b0, 10, t1);
        chk("t6_wr_lat", t1 - tcs, 1);
        step();
        chk("t6_wr_width1", wr_n2, 1);
        wait_lvl(3, 1'b0, 10, t2);
        chk("t6_spacing", t2 - t1, 3);
        chk("t6_dbus", {a02, d2}, 9'h1A5);
        wait_lvl(4, 1'b0, 400, tb);
        chk("t6_data_wait", tb - t2, 256);
        chk("t6_total", tb - tcs, 260);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
